edge_detect: RTL and testbench

Sobel edge-detection stage directly downstream of the intensity block. It consumes the 72-bit 3x3 intensity grid (nine 8-bit intensities) and produces one edge magnitude plus an edge/no-edge flag for the centre pixel. The cartoon output stage uses the flag to blacken edge pixels. A single serial accumulator walks the 9 taps over 9 cycles, keeping area low at the cost of an 11-cycle cadence.

---
 rtl/edge_detect_if.sv | 29 ++
 rtl/edge_detect.sv | 158 +++++++++++++++
 tb/tb_edge_detect.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_if.sv
// Handshake/bus bundle between the intensity block and the Sobel edge-detection stage.
// master: intensity side, drives the 3x3 grid and the start request, observes status/result.
// slave : edge_detect, consumes the grid, reports busy/edge_done/edge_mag/is_edge.
interface edge_detect_if;
    logic [71:0] iGrid;              // I0..I8 row-major, I0 at [71:64], I8 at [7:0]
    logic        edgedetect_enable;  // start request, honoured only while idle
    logic        busy;               // grid being processed
    logic        edge_done;          // one-cycle pulse, result valid this cycle
    logic [7:0]  edge_mag;           // saturated |Gx|+|Gy|
    logic        is_edge;            // edge_mag >= THRESHOLD

    modport master (
        output iGrid,
        output edgedetect_enable,
        input  busy,
        input  edge_done,
        input  edge_mag,
        input  is_edge
    );

    modport slave (
        input  iGrid,
        input  edgedetect_enable,
        output busy,
        output edge_done,
        output edge_mag,
        output is_edge
    );
endinterface

// File: rtl/edge_detect.sv
// Purpose: serial Sobel edge detector; walks the 9 taps of a latched 3x3 grid through one accumulator.
// Latency: edge_done pulses 10 edges after the start request is sampled; one grid per 11 cycles.
// Backpressure: none queued; start requests arriving while busy are dropped without side effects.
//
// Ports: clk (rising edge), n_rst (synchronous, active low), bus (edge_detect_if.slave):
//   iGrid/edgedetect_enable in; busy, edge_done, edge_mag, is_edge out.
module edge_detect #(
    parameter logic [7:0] THRESHOLD = 8'd128
) (
    input  logic         clk,
    input  logic         n_rst,
    edge_detect_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        MAG   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  tap_q,   tap_d;
    logic [11:0] gx_q,    gx_d;     // two's complement, range +/-1020
    logic [11:0] gy_q,    gy_d;
    logic [71:0] grid_q,  grid_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [7:0]  mag_q,   mag_d;
    logic        edge_q,  edge_d;

    logic [7:0]  pix;
    logic [11:0] w1;                // pixel weight 1, zero-extended
    logic [11:0] w2;                // pixel weight 2, zero-extended then shifted
    logic [11:0] abs_x;
    logic [11:0] abs_y;
    logic [11:0] mag_sum;           // max 2040, top bit always zero
    logic [7:0]  mag_sat;

    // Current tap of the latched grid, row-major from the top-left pixel.
    always_comb begin
        pix = 8'h00;
        case (tap_q)
            4'd0:    pix = grid_q[71:64];
            4'd1:    pix = grid_q[63:56];
            4'd2:    pix = grid_q[55:48];
            4'd3:    pix = grid_q[47:40];
            4'd4:    pix = grid_q[39:32];
            4'd5:    pix = grid_q[31:24];
            4'd6:    pix = grid_q[23:16];
            4'd7:    pix = grid_q[15:8];
            4'd8:    pix = grid_q[7:0];
            default: pix = 8'h00;
        endcase
    end

    assign w1 = {4'b0000, pix};
    assign w2 = {3'b000, pix, 1'b0};

    // -1020 negates exactly in 12 bits, so no saturation case is needed here.
    assign abs_x   = gx_q[11] ? (~gx_q + 12'd1) : gx_q;
    assign abs_y   = gy_q[11] ? (~gy_q + 12'd1) : gy_q;
    assign mag_sum = abs_x + abs_y;
    assign mag_sat = (mag_sum > 12'd255) ? 8'hFF : mag_sum[7:0];

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        grid_d  = grid_q;
        done_d  = 1'b0;
        mag_d   = mag_q;
        edge_d  = edge_q;

        case (state_q)
            IDLE: begin
                if (bus.edgedetect_enable) begin
                    grid_d  = bus.iGrid;
                    gx_d    = 12'd0;
                    gy_d    = 12'd0;
                    tap_d   = 4'd0;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                // Gx: left column negative, right column positive, middle row doubled.
                case (tap_q)
                    4'd0:    gx_d = gx_q - w1;
                    4'd2:    gx_d = gx_q + w1;
                    4'd3:    gx_d = gx_q - w2;
                    4'd5:    gx_d = gx_q + w2;
                    4'd6:    gx_d = gx_q - w1;
                    4'd8:    gx_d = gx_q + w1;
                    default: gx_d = gx_q;
                endcase
                // Gy: top row negative, bottom row positive, middle column doubled.
                case (tap_q)
                    4'd0:    gy_d = gy_q - w1;
                    4'd1:    gy_d = gy_q - w2;
                    4'd2:    gy_d = gy_q - w1;
                    4'd6:    gy_d = gy_q + w1;
                    4'd7:    gy_d = gy_q + w2;
                    4'd8:    gy_d = gy_q + w1;
                    default: gy_d = gy_q;
                endcase
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd8) begin
                    state_d = MAG;
                end
            end

            MAG: begin
                mag_d   = mag_sat;
                edge_d  = (mag_sat >= THRESHOLD);
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy tracks the state being entered, so it drops together with the done pulse.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            tap_q   <= 4'd0;
            gx_q    <= 12'd0;
            gy_q    <= 12'd0;
            grid_q  <= 72'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mag_q   <= 8'd0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            grid_q  <= grid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mag_q   <= mag_d;
            edge_q  <= edge_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.edge_done = done_q;
    assign bus.edge_mag  = mag_q;
    assign bus.is_edge   = edge_q;

endmodule

// File: tb/tb_edge_detect.sv
module tb_edge_detect;

    logic tb_clk;
    logic n_rst;
    int   n_cmp;
    int   n_bad;

    edge_detect_if bus ();

    edge_detect #(.THRESHOLD(8'd128)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Reference: direct 3x3 convolution with the Sobel kernels, then abs, sum, clamp.
    function automatic logic [8:0] model(input logic [71:0] grid);
        int kx[9];
        int ky[9];
        int gx;
        int gy;
        int m;
        int p;
        logic [71:0] g;
        logic [7:0]  sat;
        kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        g  = grid;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 9; i++) begin
            p  = int'(g[71 - 8 * i -: 8]);
            gx = gx + kx[i] * p;
            gy = gy + ky[i] * p;
        end
        m   = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat = (m > 255) ? 8'd255 : 8'(m);
        return {(sat >= 8'd128), sat};
    endfunction

    function automatic logic [71:0] rows3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        return {a, b, c, a, b, c, a, b, c};
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until edge_done is seen; the count is how many edges that took (40 = expired).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.edge_done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_grid(input string tag, input logic [71:0] grid,
                            input logic [7:0] exp_mag, input logic exp_edge);
        int c;
        bus.iGrid             = grid;
        bus.edgedetect_enable = 1'b1;
        tick();
        bus.edgedetect_enable = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(c);
        check({tag, "_lat"}, 32'(c + 1), 32'd10 + 32'd1);
        check({tag, "_mag"}, 32'(bus.edge_mag), 32'(exp_mag));
        check({tag, "_edge"}, 32'(bus.is_edge), 32'(exp_edge));
        tick();
    endtask

    initial begin
        int          c;
        int          ndone;
        logic [71:0] g;
        logic [8:0]  r;
        logic [7:0]  base;

        n_cmp = 0;
        n_bad = 0;
        n_rst = 1'b0;
        bus.iGrid             = 72'd0;
        bus.edgedetect_enable = 1'b1;   // reset must override a pending start

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.edge_done), 32'd0);
        check("rst_mag", 32'(bus.edge_mag), 32'd0);
        check("rst_edge", 32'(bus.is_edge), 32'd0);
        bus.edgedetect_enable = 1'b0;
        n_rst = 1'b1;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Directed patterns
        run_grid("uniform", rows3(8'd100, 8'd100, 8'd100), 8'd0, 1'b0);
        run_grid("vstep", rows3(8'd0, 8'd128, 8'd255), 8'd255, 1'b1);
        run_grid("hstep", {8'd10, 8'd10, 8'd10, 8'd30, 8'd30, 8'd30, 8'd50, 8'd50, 8'd50},
                 8'd160, 1'b1);
        run_grid("ramp_up", rows3(8'd10, 8'd12, 8'd14), 8'd16, 1'b0);
        run_grid("ramp_dn", rows3(8'd14, 8'd12, 8'd10), 8'd16, 1'b0);

        // Mixed grid: grid changed after latch, enable while busy, back-to-back restart
        bus.iGrid = {8'd20, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd144, 8'd160};
        bus.edgedetect_enable = 1'b1;
        tick();                                 // E0
        bus.edgedetect_enable = 1'b0;
        tick();                                 // E1
        bus.iGrid = rows3(8'd255, 8'd0, 8'd0);
        tick();                                 // E2
        tick();                                 // E3
        bus.edgedetect_enable = 1'b1;
        tick();                                 // E4, ignored
        bus.edgedetect_enable = 1'b0;
        check("mix_busy_e4", 32'(bus.busy), 32'd1);
        check("mix_nodone_e4", 32'(bus.edge_done), 32'd0);
        wait_done(c);
        check("mix_lat", 32'(c + 4), 32'd10);
        check("mix_mag", 32'(bus.edge_mag), 32'd255);
        check("mix_edge", 32'(bus.is_edge), 32'd1);
        check("mix_busy_done", 32'(bus.busy), 32'd0);
        bus.iGrid             = rows3(8'd10, 8'd12, 8'd14);
        bus.edgedetect_enable = 1'b1;
        tick();                                 // E11, accepted
        bus.edgedetect_enable = 1'b0;
        check("b2b_done_pulse", 32'(bus.edge_done), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_hold_mag", 32'(bus.edge_mag), 32'd255);
        wait_done(c);
        check("b2b_gap", 32'(c + 1), 32'd11);
        check("b2b_mag", 32'(bus.edge_mag), 32'd16);
        check("b2b_edge", 32'(bus.is_edge), 32'd0);
        tick();
        tick();
        check("hold_mag", 32'(bus.edge_mag), 32'd16);
        check("hold_done", 32'(bus.edge_done), 32'd0);

        // Mid-run reset: previous result must be cleared and the run abandoned
        bus.iGrid             = rows3(8'd0, 8'd0, 8'd255);
        bus.edgedetect_enable = 1'b1;
        tick();                                 // E0
        bus.edgedetect_enable = 1'b0;
        repeat (4) tick();                      // E1..E4
        n_rst = 1'b0;
        tick();                                 // E5
        n_rst = 1'b1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_mag", 32'(bus.edge_mag), 32'd0);
        check("mrst_edge", 32'(bus.is_edge), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.edge_done === 1'b1) ndone++;
            tick();
        end
        check("mrst_no_done", 32'(ndone), 32'd0);
        run_grid("post_rst", rows3(8'd0, 8'd0, 8'd255), 8'd255, 1'b1);

        // Enable held high: one run every 11 cycles
        g = {8'd5, 8'd9, 8'd30, 8'd7, 8'd15, 8'd40, 8'd9, 8'd20, 8'd50};
        r = model(g);
        bus.iGrid             = g;
        bus.edgedetect_enable = 1'b1;
        tick();
        wait_done(c);
        check("cont_lat", 32'(c + 1), 32'd11);
        check("cont_mag1", 32'(bus.edge_mag), 32'(r[7:0]));
        tick();
        wait_done(c);
        bus.edgedetect_enable = 1'b0;
        check("cont_gap", 32'(c + 1), 32'd11);
        check("cont_mag2", 32'(bus.edge_mag), 32'(r[7:0]));
        check("cont_edge2", 32'(bus.is_edge), 32'(r[8]));
        repeat (2) tick();

        // Randomised grids against the reference model
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) begin
                for (int i = 0; i < 9; i++) g[71 - 8 * i -: 8] = 8'($urandom_range(0, 255));
            end else begin
                base = 8'($urandom_range(0, 200));
                for (int i = 0; i < 9; i++)
                    g[71 - 8 * i -: 8] = base + 8'($urandom_range(0, 40));
            end
            r = model(g);
            run_grid("rand", g, r[7:0], r[8]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
